fetch_seq_ctrl: RTL and testbench

Sequencing controller for the dual-issue instruction-fetch stage. It owns the fetch buffer's write port during program load: it accepts a valid/ready instruction stream and drives load_en, instr_load_addr and the write data. During execution it gates the fetch stage through fetch_stall and flush, and detects the end of the program to halt the pipeline. It sits between the testbench/loader front end and the IF stage, alongside the ID hazard logic.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_seq_ctrl_if.sv | 25 ++
 rtl/fetch_seq_ctrl_load_seq.sv | 64 ++++++
 rtl/fetch_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared sizes and state encoding for the fetch sequencing controller
package fetch_pkg;

    localparam int DEPTH     = 512;
    localparam int AW        = $clog2(DEPTH);
    localparam int IW        = 32;
    localparam int DRAIN_CYC = 6;
    localparam int FLUSH_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_RUN   = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DRAIN = 3'd5,
        ST_HALT  = 3'd6
    } state_t;

endpackage

// File: rtl/fetch_seq_ctrl_if.sv
// rtl/fetch_seq_ctrl_if.sv - loader stream and fetch-buffer write port bundle
interface fetch_seq_ctrl_if #(
    parameter int AW = fetch_pkg::AW
);
    import fetch_pkg::*;

    logic          prog_valid;
    logic [IW-1:0] prog_data;
    logic          prog_last;
    logic          prog_ready;
    logic          load_en;
    logic [AW-1:0] instr_load_addr;
    logic [IW-1:0] instruction_in;

    modport master (
        output prog_valid, prog_data, prog_last,
        input  prog_ready, load_en, instr_load_addr, instruction_in
    );

    modport slave (
        input  prog_valid, prog_data, prog_last,
        output prog_ready, load_en, instr_load_addr, instruction_in
    );

endinterface

// File: rtl/fetch_seq_ctrl_load_seq.sv
// rtl/fetch_seq_ctrl_load_seq.sv - LOAD-phase beat counter and registered fetch-buffer write port
module fetch_load_seq
    import fetch_pkg::*;
#(
    parameter int DEPTH = fetch_pkg::DEPTH,
    parameter int AW    = fetch_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          active_i,
    input  logic          prog_valid_i,
    input  logic [IW-1:0] prog_data_i,
    input  logic          prog_last_i,
    output logic          done_o,
    output logic [AW:0]   len_o,
    output logic          load_en_o,
    output logic [AW-1:0] addr_o,
    output logic [IW-1:0] data_o
);

    logic [AW-1:0] cnt_q, cnt_d;
    logic          load_en_q;
    logic [AW-1:0] addr_q;
    logic [IW-1:0] data_q;
    logic          accept;
    logic          at_end;

    assign accept = active_i & prog_valid_i;
    assign at_end = (cnt_q == AW'(DEPTH - 1));
    assign done_o = accept & (prog_last_i | at_end);
    assign len_o  = {1'b0, cnt_q} + (AW + 1)'(1);

    // The counter parks at DEPTH-1 so the write address can never wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (accept && !at_end) begin
            cnt_d = cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            load_en_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            load_en_q <= accept;
            if (accept) begin
                addr_q <= cnt_q;
                data_q <= prog_data_i;
            end
        end
    end

    assign load_en_o = load_en_q;
    assign addr_o    = addr_q;
    assign data_o    = data_q;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - fetch-stage sequencer: program load, run gating, flush and end-of-program halt
module fetch_seq_ctrl
    import fetch_pkg::*;
#(
    parameter int DEPTH     = fetch_pkg::DEPTH,
    parameter int AW        = fetch_pkg::AW,
    parameter int DRAIN_CYC = fetch_pkg::DRAIN_CYC,
    parameter int FLUSH_CYC = fetch_pkg::FLUSH_CYC
) (
    input  logic               clk,
    input  logic               rst,
    fetch_seq_ctrl_if.slave    bus,
    input  logic               load_start_i,
    input  logic               run_start_i,
    input  logic [AW-1:0]      pc_fetch_i,
    input  logic               ex_stall_i,
    input  logic               br_resolve_i,
    input  logic               br_taken_i,
    input  logic               halt_req_i,
    output logic               fetch_stall_o,
    output logic               flush_o,
    output logic               running_o,
    output logic               halted_o,
    output logic [AW:0]        prog_len_o,
    output logic [31:0]        run_cycles_o
);

    localparam int CW = 8;

    state_t        state_q, state_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;
    logic [CW-1:0] drain_cnt_q, drain_cnt_d;
    logic [AW:0]   prog_len_q, prog_len_d;
    logic [31:0]   run_cycles_q, run_cycles_d;

    logic          ld_start;
    logic          ld_done;
    logic [AW:0]   ld_len;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [IW-1:0] ld_data;
    logic          taken;
    logic          active_run;
    logic [AW:0]   end_pc;
    logic          past_end;

    assign taken      = br_resolve_i & br_taken_i;
    assign active_run = (state_q == ST_RUN) || (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
    // Fetch is dual-issue, so the PC only lands on even slots.
    assign end_pc     = (prog_len_q + (AW + 1)'(1)) & ~((AW + 1)'(1));
    assign past_end   = ({1'b0, pc_fetch_i} >= end_pc);

    fetch_load_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_load_seq (
        .clk          (clk),
        .rst          (rst),
        .start_i      (ld_start),
        .active_i     (state_q == ST_LOAD),
        .prog_valid_i (bus.prog_valid),
        .prog_data_i  (bus.prog_data),
        .prog_last_i  (bus.prog_last),
        .done_o       (ld_done),
        .len_o        (ld_len),
        .load_en_o    (ld_en),
        .addr_o       (ld_addr),
        .data_o       (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        prog_len_d   = prog_len_q;
        run_cycles_d = run_cycles_q;
        ld_start     = 1'b0;

        if (active_run && run_cycles_q != 32'hFFFF_FFFF) begin
            run_cycles_d = run_cycles_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (load_start_i) begin
                    state_d  = ST_LOAD;
                    ld_start = 1'b1;
                end
            end
            ST_LOAD: begin
                if (ld_done) begin
                    state_d    = ST_READY;
                    prog_len_d = ld_len;
                end
            end
            ST_READY: begin
                if (run_start_i) begin
                    state_d      = ST_RUN;
                    run_cycles_d = '0;
                end else if (load_start_i) begin
                    state_d  = ST_LOAD;
                    ld_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_req_i) begin
                    state_d = ST_HALT;
                end else if (taken) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end else if (past_end && !ex_stall_i) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                if (halt_req_i) begin
                    state_d = ST_HALT;
                end else if (taken) begin
                    flush_cnt_d = '0;
                end else if (flush_cnt_q == CW'(FLUSH_CYC - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (halt_req_i) begin
                    state_d = ST_HALT;
                end else if (taken) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end else if (drain_cnt_q == CW'(DRAIN_CYC - 1)) begin
                    state_d = ST_HALT;
                end else begin
                    drain_cnt_d = drain_cnt_q + CW'(1);
                end
            end
            ST_HALT: begin
                if (load_start_i) begin
                    state_d  = ST_LOAD;
                    ld_start = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ld_start) begin
            prog_len_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            flush_cnt_q  <= '0;
            drain_cnt_q  <= '0;
            prog_len_q   <= '0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            prog_len_q   <= prog_len_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    assign bus.prog_ready      = (state_q == ST_LOAD);
    assign bus.load_en         = ld_en;
    assign bus.instr_load_addr = ld_addr;
    assign bus.instruction_in  = ld_data;

    assign fetch_stall_o = (state_q == ST_RUN) ? ex_stall_i : (state_q != ST_FLUSH);
    assign flush_o       = (state_q == ST_FLUSH);
    assign running_o     = active_run;
    assign halted_o      = (state_q == ST_HALT);
    assign prog_len_o    = prog_len_q;
    assign run_cycles_o  = run_cycles_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - scoreboard bench for fetch_seq_ctrl
module tb_fetch_seq_ctrl;
    import fetch_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start, run_start, ex_stall, br_resolve, br_taken, halt_req;
    logic [AW-1:0] pc_fetch;
    logic          fetch_stall, flush, running, halted;
    logic [AW:0]   prog_len;
    logic [31:0]   run_cycles;

    int            n_vec = 0;
    int            n_err = 0;
    int            n_writes = 0;
    logic [AW-1:0] last_addr;
    logic [63:0]   sb_q[$];
    int            model_cnt;
    bit            model_active;
    int            w0;

    fetch_seq_ctrl_if bus ();

    fetch_seq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .load_start_i  (load_start),
        .run_start_i   (run_start),
        .pc_fetch_i    (pc_fetch),
        .ex_stall_i    (ex_stall),
        .br_resolve_i  (br_resolve),
        .br_taken_i    (br_taken),
        .halt_req_i    (halt_req),
        .fetch_stall_o (fetch_stall),
        .flush_o       (flush),
        .running_o     (running),
        .halted_o      (halted),
        .prog_len_o    (prog_len),
        .run_cycles_o  (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wr_word(input logic [AW-1:0] a, input logic [31:0] d);
        return 64'({1'b1, a, d});
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.load_en) begin
            logic [63:0] exp_w;
            exp_w = (sb_q.size() != 0) ? sb_q.pop_front() : 64'd0;
            n_writes++;
            last_addr = bus.instr_load_addr;
            chk("write", wr_word(bus.instr_load_addr, bus.instruction_in), exp_w);
        end
    end

    task automatic load_prog(input int n, input logic [31:0] base, input bit use_last, input bit toggle);
        int sent = 0;
        int cyc = 0;
        load_start   = 1'b1;
        model_cnt    = 0;
        model_active = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        while (sent < n) begin
            if (toggle && (cyc % 2 == 1)) begin
                bus.prog_valid = 1'b0;
            end else begin
                bus.prog_valid = 1'b1;
                bus.prog_data  = base + 32'(sent);
                bus.prog_last  = use_last && (sent == n - 1);
                if (model_active) begin
                    sb_q.push_back(wr_word(AW'(model_cnt), base + 32'(sent)));
                    model_cnt++;
                    if (bus.prog_last || model_cnt == DEPTH) model_active = 1'b0;
                end
                sent++;
            end
            cyc++;
            @(negedge clk);
        end
        bus.prog_valid = 1'b0;
        bus.prog_last  = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_run();
        run_start = 1'b1;
        pc_fetch  = '0;
        @(negedge clk);
        run_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        {load_start, run_start, ex_stall, br_resolve, br_taken, halt_req} = '0;
        pc_fetch = '0;
        bus.prog_valid = 1'b0;
        bus.prog_data  = '0;
        bus.prog_last  = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_prog_ready", bus.prog_ready, 0);
        chk("rst_load_en", bus.load_en, 0);
        chk("rst_fetch_stall", fetch_stall, 1);
        chk("rst_flush_run_halt", {flush, running, halted}, 0);
        chk("rst_addr_data", {bus.instr_load_addr, bus.instruction_in}, 0);
        chk("rst_len_cycles", {prog_len, run_cycles}, 0);
        rst = 1'b0;
        pc_fetch = '1;
        pulse_run();
        chk("idle_ignores_run", dut.state_q, ST_IDLE);

        // basic load of five words
        w0 = n_writes;
        load_prog(5, 32'hA0, 1'b1, 1'b0);
        chk("load5_writes", n_writes - w0, 5);
        chk("load5_sb_empty", sb_q.size(), 0);
        chk("load5_len", prog_len, 5);
        chk("load5_state", dut.state_q, ST_READY);

        // backpressure, then overflow with no prog_last
        w0 = n_writes;
        load_prog(7, 32'hB0, 1'b1, 1'b1);
        chk("toggle_writes", n_writes - w0, 7);
        chk("toggle_len", prog_len, 7);
        w0 = n_writes;
        load_prog(600, 32'h1000, 1'b0, 1'b0);
        chk("ovf_writes", n_writes - w0, 512);
        chk("ovf_last_addr", last_addr, 511);
        chk("ovf_len", prog_len, 512);
        chk("ovf_ready_low", bus.prog_ready, 0);
        chk("ovf_sb_empty", sb_q.size(), 0);

        // run to the end of a five-word program
        load_prog(5, 32'hA0, 1'b1, 1'b0);
        pulse_run();
        chk("run_running", running, 1);
        chk("run_stall_low", fetch_stall, 0);
        for (int i = 0; i < 4; i++) begin
            pc_fetch = AW'(2 * i);
            @(negedge clk);
        end
        chk("end_drain", dut.state_q, ST_DRAIN);
        chk("drain_stall", fetch_stall, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("drain_not_halted", halted, 0);
        end
        @(negedge clk);
        chk("drain_halted", halted, 1);
        chk("halt_cycles", run_cycles, 10);
        repeat (3) @(negedge clk);
        chk("halt_cycles_frozen", run_cycles, 10);
        chk("halt_not_running", running, 0);

        // taken branch flushes for exactly two cycles
        load_prog(5, 32'hA0, 1'b1, 1'b0);
        pulse_run();
        br_resolve = 1'b1; br_taken = 1'b1;
        @(negedge clk);
        br_resolve = 1'b0; br_taken = 1'b0;
        chk("br_flush1", {flush, fetch_stall}, 2'b10);
        @(negedge clk);
        chk("br_flush2", flush, 1);
        @(negedge clk);
        chk("br_flush_done", flush, 0);
        chk("br_back_run", dut.state_q, ST_RUN);
        pc_fetch = AW'(6);
        br_resolve = 1'b1; br_taken = 1'b1;
        @(negedge clk);
        br_resolve = 1'b0; br_taken = 1'b0;
        chk("br_beats_end", dut.state_q, ST_FLUSH);
        repeat (2) @(negedge clk);
        chk("br_run_again", dut.state_q, ST_RUN);
        @(negedge clk);
        chk("br_drain", dut.state_q, ST_DRAIN);
        br_resolve = 1'b1; br_taken = 1'b1;
        @(negedge clk);
        br_resolve = 1'b0; br_taken = 1'b0;
        pc_fetch = '0;
        chk("drain_to_flush", dut.state_q, ST_FLUSH);
        repeat (2) @(negedge clk);
        chk("flush_to_run", dut.state_q, ST_RUN);

        // ex_stall gates fetch combinationally and blocks end detection
        ex_stall = 1'b1;
        pc_fetch = AW'(8);
        #1;
        chk("stall_same_cycle", fetch_stall, 1);
        @(negedge clk);
        chk("stall_no_drain", dut.state_q, ST_RUN);
        ex_stall = 1'b0;
        #1;
        chk("unstall_fetch", fetch_stall, 0);
        @(negedge clk);
        chk("unstall_drain", dut.state_q, ST_DRAIN);

        // halt overrides a concurrent taken branch during FLUSH
        br_resolve = 1'b1; br_taken = 1'b1;
        @(negedge clk);
        chk("halt_pre_flush", dut.state_q, ST_FLUSH);
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0; br_resolve = 1'b0; br_taken = 1'b0;
        chk("halt_state", dut.state_q, ST_HALT);
        chk("halt_outs", {halted, running, flush, fetch_stall}, 4'b1001);
        pulse_run();
        chk("halt_sticky", dut.state_q, ST_HALT);

        // asynchronous reset in the middle of a load
        w0 = n_writes;
        load_prog(3, 32'hC0, 1'b0, 1'b0);
        chk("midload_writes", n_writes - w0, 3);
        chk("midload_state", dut.state_q, ST_LOAD);
        #1 rst = 1'b1;
        #1;
        chk("arst_state", dut.state_q, ST_IDLE);
        chk("arst_ready_en", {bus.prog_ready, bus.load_en}, 0);
        chk("arst_addr_data", {bus.instr_load_addr, bus.instruction_in}, 0);
        chk("arst_len_cycles", {prog_len, run_cycles}, 0);
        chk("arst_flags", {fetch_stall, flush, running, halted}, 4'b1000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", dut.state_q, ST_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
